fetch_decode_stage: RTL and testbench

Upstream pipeline stage of the processor datapath: holds the program counter and a small writable instruction memory, fetches one instruction per cycle, and registers it into the IF/ID pipeline register. Splits the registered instruction into the `func`, `rd` and `rs` fields. Its `func` and `status` outputs drive the control unit's `func` and `status` inputs directly. Supports stall, flush, taken-branch redirect and a HALT instruction.

---
 rtl/fetch_decode_stage.sv | 99 +++++++++
 tb/tb_fetch_decode_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// Fetch stage: program counter, writable instruction memory and IF/ID register,
// with stall, flush, branch redirect and HALT handling; decodes func/rd/rs.
module fetch_decode_stage #(
   parameter int          IW      = 8,
   parameter int          AW      = 4,
   parameter int          DEPTH   = 16,
   parameter logic [7:0]  HALT_OP = 8'hFF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic          run,
   input  logic          stall,
   input  logic          flush,
   input  logic          branch_taken,
   input  logic [AW-1:0] branch_target,
   output logic [AW-1:0] pc_out,
   output logic [IW-1:0] instr,
   output logic [1:0]    func,
   output logic [2:0]    rd,
   output logic [2:0]    rs,
   output logic          status,
   output logic          halted
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] FETCH = 2'b01;
   localparam logic [1:0] HALT  = 2'b10;

   logic [1:0]    state;
   logic [AW-1:0] pc;
   logic [IW-1:0] imem [DEPTH];
   logic [IW-1:0] fetch_word;

   // Combinational read: a same-edge write is seen only from the next cycle on.
   assign fetch_word = imem[pc];

   always_ff @(posedge clk) begin
      if (prog_we)
         imem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         pc     <= '0;
         pc_out <= '0;
         instr  <= '0;
         status <= 1'b0;
         halted <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               status <= 1'b0;
               if (run)
                  state <= FETCH;
            end
            FETCH: begin
               if (!run) begin
                  state  <= IDLE;
                  status <= 1'b0;
               end else if (branch_taken) begin
                  pc     <= branch_target;
                  status <= 1'b0;
               end else if (flush) begin
                  status <= 1'b0;
               end else if (stall) begin
                  status <= status;
               end else if (fetch_word == IW'(HALT_OP)) begin
                  // The HALT word itself never becomes a valid IF/ID entry.
                  state  <= HALT;
                  status <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  instr  <= fetch_word;
                  pc_out <= pc;
                  status <= 1'b1;
                  pc     <= pc + 1'b1;
               end
            end
            HALT: begin
               status <= 1'b0;
               halted <= 1'b1;
            end
            default: begin
               state  <= IDLE;
               status <= 1'b0;
            end
         endcase
      end
   end

   assign func = instr[7:6];
   assign rd   = instr[5:3];
   assign rs   = instr[2:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: fetch, stall, branch, wrap, flush,
// same-address write, run toggling, HALT and asynchronous reset.
module tb_fetch_decode_stage;

   logic       clk;
   logic       reset;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic       run;
   logic       stall;
   logic       flush;
   logic       branch_taken;
   logic [3:0] branch_target;
   logic [3:0] pc_out;
   logic [7:0] instr;
   logic [1:0] func;
   logic [2:0] rd;
   logic [2:0] rs;
   logic       status;
   logic       halted;

   int checks = 0;
   int errors = 0;

   fetch_decode_stage #(.IW(8), .AW(4), .DEPTH(16), .HALT_OP(8'hFF)) dut (
      .clk           (clk),
      .reset         (reset),
      .prog_we       (prog_we),
      .prog_addr     (prog_addr),
      .prog_data     (prog_data),
      .run           (run),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc_out        (pc_out),
      .instr         (instr),
      .func          (func),
      .rd            (rd),
      .rs            (rs),
      .status        (status),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_if(input string tag, input logic st, input logic [3:0] pc, input logic [7:0] ins);
      check({tag, ".status"}, 32'(status), 32'(st));
      check({tag, ".pc_out"}, 32'(pc_out), 32'(pc));
      check({tag, ".instr"},  32'(instr),  32'(ins));
   endtask

   initial begin
      reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      run = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
      #1 reset = 1'b1;
      #1;
      expect_if("reset", 1'b0, 4'h0, 8'h00);
      check("reset.halted", 32'(halted), 32'd0);
      check("reset.fields", {26'd0, func, rd, rs}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Program: 0..3 = 4B 92 C1 00, 4..15 = 8'h10+addr
      for (int i = 0; i < 16; i++) begin
         prog_we   = 1'b1;
         prog_addr = 4'(i);
         case (i)
            0: prog_data = 8'h4B;
            1: prog_data = 8'h92;
            2: prog_data = 8'hC1;
            3: prog_data = 8'h00;
            default: prog_data = 8'h10 + 8'(i);
         endcase
         tick();
      end
      prog_we = 1'b0;
      check("idle.status", 32'(status), 32'd0);

      // Basic fetch
      run = 1'b1;
      tick();
      check("e1.status", 32'(status), 32'd0);
      tick();
      expect_if("e2", 1'b1, 4'h0, 8'h4B);
      check("e2.fields", {26'd0, func, rd, rs}, {26'd0, 2'd1, 3'd1, 3'd3});
      tick();
      expect_if("e3", 1'b1, 4'h1, 8'h92);
      check("e3.fields", {26'd0, func, rd, rs}, {26'd0, 2'd2, 3'd2, 3'd2});

      // Stall two cycles
      stall = 1'b1;
      tick();
      expect_if("stall1", 1'b1, 4'h1, 8'h92);
      tick();
      expect_if("stall2", 1'b1, 4'h1, 8'h92);
      stall = 1'b0;
      tick();
      expect_if("unstall", 1'b1, 4'h2, 8'hC1);

      // Branch together with stall: branch wins
      branch_taken = 1'b1; branch_target = 4'hA; stall = 1'b1;
      tick();
      check("br.status", 32'(status), 32'd0);
      branch_taken = 1'b0; stall = 1'b0;
      tick();
      expect_if("br.target", 1'b1, 4'hA, 8'h1A);

      // Wrap past address 15
      for (int i = 0; i < 5; i++) tick();
      expect_if("wrap.f", 1'b1, 4'hF, 8'h1F);
      tick();
      expect_if("wrap.0", 1'b1, 4'h0, 8'h4B);

      // Flush one cycle
      flush = 1'b1;
      tick();
      check("flush.status", 32'(status), 32'd0);
      check("flush.pc_out", 32'(pc_out), 32'd0);
      flush = 1'b0;
      tick();
      expect_if("postflush", 1'b1, 4'h1, 8'h92);

      // Same-address write while fetching address 3
      tick();
      expect_if("pre_wr", 1'b1, 4'h2, 8'hC1);
      prog_we = 1'b1; prog_addr = 4'h3; prog_data = 8'h55;
      tick();
      prog_we = 1'b0;
      expect_if("wr.old", 1'b1, 4'h3, 8'h00);
      branch_taken = 1'b1; branch_target = 4'h3;
      tick();
      check("br3.status", 32'(status), 32'd0);
      branch_taken = 1'b0;
      tick();
      expect_if("wr.new", 1'b1, 4'h3, 8'h55);

      // Run toggle, and plant HALT at address 5 while idle
      run = 1'b0;
      prog_we = 1'b1; prog_addr = 4'h5; prog_data = 8'hFF;
      tick();
      prog_we = 1'b0;
      check("runoff.status", 32'(status), 32'd0);
      run = 1'b1;
      tick();
      check("rerun.e1", 32'(status), 32'd0);
      tick();
      expect_if("rerun.e2", 1'b1, 4'h4, 8'h14);
      check("rerun.halted", 32'(halted), 32'd0);

      // HALT
      tick();
      check("halt.halted", 32'(halted), 32'd1);
      expect_if("halt", 1'b0, 4'h4, 8'h14);
      run = 1'b0; branch_taken = 1'b1; branch_target = 4'h0;
      tick();
      check("halt.abs1", 32'({halted, status}), 32'b10);
      run = 1'b1; branch_taken = 1'b0;
      tick();
      check("halt.abs2", 32'({halted, status}), 32'b10);
      check("halt.pc_out", 32'(pc_out), 32'd4);

      // Asynchronous reset mid-cycle
      #2 reset = 1'b1;
      #1;
      expect_if("areset", 1'b0, 4'h0, 8'h00);
      check("areset.halted", 32'(halted), 32'd0);
      check("areset.fields", {26'd0, func, rd, rs}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("post.e1", 32'(status), 32'd0);
      tick();
      expect_if("post.e2", 1'b1, 4'h0, 8'h4B);
      for (int i = 0; i < 3; i++) tick();
      expect_if("post.retained", 1'b1, 4'h3, 8'h55);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
